uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: data bits per frame.
REQ-002 SHALL have parameter NB_STOP, default 16: tick count at which the stop bit is sampled, i.e. stop-bit length in ticks.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_tick, input, 1: one-clk pulse at 16x baud rate, from the baud generator.
REQ-006 SHALL have port i_rx, input, 1: serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port o_data, output, NB_DATA: last correctly framed byte, feeds uart_interface i_rx.
REQ-008 SHALL have port o_rxDone, output, 1: one-clk pulse marking o_data valid, feeds uart_interface i_rxDone.
REQ-009 SHALL have port o_frame_err, output, 1: one-clk pulse when a sampled stop bit is low.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer (reset value 1); all line decisions use the synchronized bit.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 SHALL hold a 4-bit tick counter and a bit counter wide enough for NB_DATA-1; both advance only on clk edges where i_tick=1.
REQ-013 IDLE: synchronized line low -> START, tick counter cleared; otherwise stay.
REQ-014 START: on tick with counter=7, line low -> DATA with both counters cleared; line high -> IDLE (false start, no output activity).
REQ-015 DATA: on tick with counter=15, sample line into the shift register MSB and shift right (LSB-first reception), clear tick counter; after bit NB_DATA-1 -> STOP with counter cleared.
REQ-016 STOP: on tick with counter=NB_STOP-1, sample line, go to IDLE.
REQ-017 Stop sample high: SHALL load o_data from the shift register and pulse o_rxDone high for exactly one clk, in the cycle after that tick edge.
REQ-018 Stop sample low: SHALL pulse o_frame_err for one clk; o_rxDone stays low; o_data keeps its previous value.
REQ-019 o_data SHALL be stable between o_rxDone pulses; the shift register SHALL never drive o_data directly.
REQ-020 Ticks arriving while in IDLE SHALL have no effect; ticks are never counted outside START/DATA/STOP.
REQ-021 A new start bit SHALL be accepted in the clk immediately after the return to IDLE, so back-to-back frames with one stop bit are received without loss.
REQ-022 o_rxDone and o_frame_err SHALL never be high in the same cycle.
REQ-023 Line held low continuously SHALL produce repeated frame errors (byte 0x00, stop low); the block SHALL never lock up.

Reset
REQ-024 i_rst_n low SHALL asynchronously force IDLE, counters 0, shift register 0, synchronizer flops 1, o_data=0, o_rxDone=0, o_frame_err=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no rxDone or frame_err pulse; reception resumes at the next falling edge after release.

Verification
REQ-026 Frame 0x08 (start, LSB-first, stop high), i_tick every 10 clk -> exactly one o_rxDone pulse, o_data=0x08, o_frame_err never high.
REQ-027 Back-to-back frames 0x20 then 0x22 with no idle gap -> two o_rxDone pulses, o_data 0x20 then 0x22.
REQ-028 i_rx low for 4 ticks then high -> returns to IDLE, no o_rxDone or o_frame_err; a following 0x10 frame is received correctly.
REQ-029 After a good 0x01 frame, send 0x55 with stop bit low -> one o_frame_err pulse, no o_rxDone, o_data stays 0x01.
REQ-030 Assert i_rst_n low during bit 3 of frame 0xA5, release, send 0x3C -> all outputs 0 during reset, no pulse for 0xA5, o_data=0x3C with one o_rxDone.
REQ-031 Chain with uart_interface: send 0x08,0x01,0x10,0x01,0x20,0x20 serially -> uart_interface o_data=2 (ADD).

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one start bit, NB_DATA data bits,
// stop bit sampled NB_STOP ticks into the stop period.
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rxDone,
  output logic               o_frame_err
);

  localparam int NB_BCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [3:0]           r_tick_cnt;
  logic [NB_BCNT-1:0]   r_bit_cnt;
  logic [NB_DATA-1:0]   r_shreg;
  logic [NB_DATA-1:0]   r_data;
  logic                 r_rx_done;
  logic                 r_frame_err;

  // Handshake: o_rxDone is a one-clk valid pulse qualifying o_data; there is
  // no ready/backpressure, and o_data holds until the next o_rxDone.
  assign o_data      = r_data;
  assign o_rxDone    = r_rx_done;
  assign o_frame_err = r_frame_err;

  // Reset value 1 keeps the idle-high line from looking like a start bit.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rx_sync) begin
            r_state    <= START;
            r_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (i_tick) begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= 4'd0;
              if (!r_rx_sync) begin
                r_state   <= DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_tick_cnt <= 4'd0;
              r_shreg    <= {r_rx_sync, r_shreg[NB_DATA-1:1]};
              if (r_bit_cnt == NB_BCNT'(NB_DATA - 1)) begin
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (r_tick_cnt == 4'(NB_STOP - 1)) begin
              r_tick_cnt <= 4'd0;
              r_state    <= IDLE;
              if (r_rx_sync) begin
                r_data    <= r_shreg;
                r_rx_done <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven on tick boundaries, a
// monitor matching every o_rxDone against an expected-byte queue.
module tb_uart_rx;

  logic       clk;
  logic       i_rst_n;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rxDone;
  logic       o_frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int tick_div = 0;
  int tick_num = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] exp_q[$];

  uart_rx #(.NB_DATA(8), .NB_STOP(16)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_rxDone    (o_rxDone),
    .o_frame_err (o_frame_err)
  );

  // ---------------- clock / tick / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_div == 9) begin
      tick_div = 0;
      i_tick   = 1'b1;
      tick_num = tick_num + 1;
    end else begin
      tick_div = tick_div + 1;
      i_tick   = 1'b0;
    end
  end

  initial begin
    #700us;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    n_errors = n_errors + 1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_rxDone || o_frame_err)
        check("done_ferr_exclusive", {31'd0, o_rxDone & o_frame_err}, 32'd0);
      if (o_rxDone) begin
        done_cnt = done_cnt + 1;
        check("exp_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0)
          check("rx_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end else if (o_data !== last_data) begin
        check("data_stable", {24'd0, o_data}, {24'd0, last_data});
      end
      if (o_frame_err) ferr_cnt = ferr_cnt + 1;
    end
    last_data = o_data;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    int target;
    target = tick_num + n;
    wait (tick_num >= target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, o_data}, 32'd0);
    check({tag, "_done"}, {31'd0, o_rxDone}, 32'd0);
    check({tag, "_ferr"}, {31'd0, o_frame_err}, 32'd0);
  endtask

  // abort_bit >= 0 asserts reset halfway through that data bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int abort_bit);
    wait_ticks(1);
    i_rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rx = data[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        i_rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        return;
      end
      wait_ticks(16);
    end
    i_rx = stop_bit;
    wait_ticks(16);
    i_rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] data);
    exp_q.push_back(data);
    send_frame(data, 1'b1, -1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] chain [6];
    chain[0] = 8'h08; chain[1] = 8'h01; chain[2] = 8'h10;
    chain[3] = 8'h01; chain[4] = 8'h20; chain[5] = 8'h20;

    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    i_tick  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    i_rst_n = 1'b1;

    // Idle ticks must do nothing
    wait_ticks(20);
    check("idle_done", done_cnt, 32'd0);
    check("idle_ferr", ferr_cnt, 32'd0);

    send_good(8'h08);
    wait_ticks(4);
    check("f08_done", done_cnt, 32'd1);
    check("f08_ferr", ferr_cnt, 32'd0);
    check("f08_data", {24'd0, o_data}, 32'h08);

    // Back-to-back, no idle gap between stop and next start
    send_good(8'h20);
    send_good(8'h22);
    wait_ticks(4);
    check("b2b_done", done_cnt, 32'd3);
    check("b2b_data", {24'd0, o_data}, 32'h22);

    // False start: low for 4 ticks only
    wait_ticks(1);
    i_rx = 1'b0;
    wait_ticks(4);
    i_rx = 1'b1;
    wait_ticks(20);
    check("false_done", done_cnt, 32'd3);
    check("false_ferr", ferr_cnt, 32'd0);
    send_good(8'h10);
    wait_ticks(4);
    check("f10_done", done_cnt, 32'd4);
    check("f10_data", {24'd0, o_data}, 32'h10);

    // Good 0x01 then 0x55 with a low stop bit
    send_good(8'h01);
    send_frame(8'h55, 1'b0, -1);
    wait_ticks(4);
    check("ferr_done", done_cnt, 32'd5);
    check("ferr_cnt", ferr_cnt, 32'd1);
    check("ferr_data", {24'd0, o_data}, 32'h01);

    // Reset during bit 3 of 0xA5, then 0x3C
    send_frame(8'hA5, 1'b1, 3);
    wait_ticks(20);
    check("rst_done", done_cnt, 32'd5);
    check("rst_ferr", ferr_cnt, 32'd1);
    check("rst_data", {24'd0, o_data}, 32'h00);
    send_good(8'h3C);
    wait_ticks(4);
    check("f3c_done", done_cnt, 32'd6);
    check("f3c_data", {24'd0, o_data}, 32'h3C);

    // Line stuck low: two full frames of zeros with low stop, third start
    // is released before its mid-start sample and aborts as a false start.
    wait_ticks(1);
    i_rx = 1'b0;
    wait_ticks(308);
    i_rx = 1'b1;
    wait_ticks(30);
    check("stuck_ferr", ferr_cnt, 32'd3);
    check("stuck_done", done_cnt, 32'd6);
    check("stuck_data", {24'd0, o_data}, 32'h3C);
    send_good(8'h5A);
    wait_ticks(4);
    check("recover_done", done_cnt, 32'd7);
    check("recover_data", {24'd0, o_data}, 32'h5A);

    // Command byte stream as a downstream interface would consume it
    for (int i = 0; i < 6; i++) send_good(chain[i]);
    wait_ticks(4);
    check("chain_done", done_cnt, 32'd13);
    check("chain_ferr", ferr_cnt, 32'd3);
    check("chain_data", {24'd0, o_data}, 32'h20);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
